// File: rtl/hc165_scan_pkg.sv
// Shared types for the HC165 chain scanner: FSM state encoding, chain pin
// encodings per state, and the counter width helper.
package hc165_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic shift_load;
        logic clock_in_hibit;
    } pins_t;

    // shift_load: 0 = parallel load; clock_in_hibit: 1 = hold
    localparam pins_t PINS_IDLE  = '{shift_load: 1'b1, clock_in_hibit: 1'b1};
    localparam pins_t PINS_LOAD  = '{shift_load: 1'b0, clock_in_hibit: 1'b0};
    localparam pins_t PINS_SHIFT = '{shift_load: 1'b1, clock_in_hibit: 1'b0};

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hc165_scan_ctrl_if.sv
// Host-side handshake of the HC165 scanner: scan request, auto enable and
// the busy/done/data result. 'changed' exists only with HC165_SCAN_CHANGE_EN.
interface hc165_scan_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         auto_en;
    logic         busy;
    logic         done;
    logic [W-1:0] data_out;
`ifdef HC165_SCAN_CHANGE_EN
    logic         changed;

    modport master (output start, output auto_en,
                    input busy, input done, input data_out, input changed);
    modport slave  (input start, input auto_en,
                    output busy, output done, output data_out, output changed);
`else
    modport master (output start, output auto_en,
                    input busy, input done, input data_out);
    modport slave  (input start, input auto_en,
                    output busy, output done, output data_out);
`endif
endinterface

// File: rtl/hc165_capture.sv
// Serial-in capture register for the HC165 scanner. The last bit of a scan is
// merged straight into the output word on commit (optional HC165_SCAN_CHANGE_EN).
module hc165_capture #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         commit,
    input  logic         serial_in,
    output logic [W-1:0] data
`ifdef HC165_SCAN_CHANGE_EN
    ,
    output logic         changed
`endif
);

    // Only W-1 bits need storage: the final bit arrives on the commit edge.
    logic [W-2:0] shift_reg;
    logic [W-2:0] shift_next;
    logic [W-1:0] word_next;
    logic [W-1:0] data_reg;

    assign shift_next[0] = serial_in;
    generate
        for (genvar gi = 1; gi < W - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    assign word_next = {shift_reg, serial_in};
    assign data      = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            data_reg  <= '0;
        end else begin
            if (clr) begin
                shift_reg <= '0;
            end else if (shift_en) begin
                shift_reg <= shift_next;
            end
            if (commit) begin
                data_reg <= word_next;
            end
        end
    end

`ifdef HC165_SCAN_CHANGE_EN
    logic changed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= commit && (word_next != data_reg);
        end
    end

    assign changed = changed_reg;
`endif

endmodule

// File: rtl/hc165_scan_ctrl.sv
// Sequencer for a chain of HC165 PISO registers: load, shift W bits, publish
// the word with a done pulse. Define HC165_SCAN_CHANGE_EN for the 'changed' flag.
module hc165_scan_ctrl
    import hc165_scan_pkg::*;
#(
    parameter int NUM_DEV    = 1,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    hc165_scan_ctrl_if.slave    host,
    input  logic                qh,
    output logic                shift_load,
    output logic                clock_in_hibit
);

    localparam int W     = 8 * NUM_DEV;
    localparam int BIT_W = cnt_width(W);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] LOAD  = 2'(ST_LOAD);
    localparam logic [1:0] SHIFT = 2'(ST_SHIFT);

    logic [1:0]       state_reg, state_next;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [16:0]      gap_cnt_reg;
    logic [16:0]      gap_inc;
    logic             done_reg;
    logic             auto_fire;
    logic             last_bit;
    logic [W-1:0]     cap_data;
    pins_t            pins;

    // gap_inc counts the current idle cycle, so GAP_CYCLES idle cycles pass
    // between done and the next auto load (zero gives continuous scanning).
    assign gap_inc   = gap_cnt_reg + 17'd1;
    assign auto_fire = host.auto_en && (state_reg == IDLE) && (gap_inc >= 17'(GAP_CYCLES));
    assign last_bit  = (state_reg == SHIFT) && (bit_cnt_reg == BIT_W'(W - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (host.start || auto_fire) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (state_reg)
            LOAD:    pins = PINS_LOAD;
            SHIFT:   pins = PINS_SHIFT;
            default: pins = PINS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= last_bit;

            if (state_reg == SHIFT && !last_bit) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else begin
                bit_cnt_reg <= '0;
            end

            if (!host.auto_en || last_bit) begin
                gap_cnt_reg <= '0;
            end else if (state_reg == IDLE && state_next == IDLE) begin
                gap_cnt_reg <= gap_inc;
            end
        end
    end

    hc165_capture #(
        .W(W)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_reg == LOAD),
        .shift_en  (state_reg == SHIFT),
        .commit    (last_bit),
        .serial_in (qh),
        .data      (cap_data)
`ifdef HC165_SCAN_CHANGE_EN
        ,
        .changed   (host.changed)
`endif
    );

    assign shift_load     = pins.shift_load;
    assign clock_in_hibit = pins.clock_in_hibit;
    assign host.busy      = (state_reg == LOAD) || (state_reg == SHIFT);
    assign host.done      = done_reg;
    assign host.data_out  = cap_data;

endmodule

// File: tb/tb_hc165_scan_ctrl.sv
// Bench for hc165_scan_ctrl: two instances (1 and 2 devices) driving behavioural
// HC165 chains; expected words and done cycles are queued and popped on done.
module tb_hc165_scan_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    hc165_scan_ctrl_if #(.W(8))  ifa ();
    hc165_scan_ctrl_if #(.W(16)) ifb ();

    logic sl_a, ci_a, sl_b, ci_b;
    logic [7:0]  q_a, chain_a = '0;
    logic [15:0] q_b, chain_b = '0;

    hc165_scan_ctrl #(.NUM_DEV(1), .GAP_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst_a), .host(ifa), .qh(chain_a[7]),
        .shift_load(sl_a), .clock_in_hibit(ci_a)
    );

    hc165_scan_ctrl #(.NUM_DEV(2), .GAP_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst_b), .host(ifb), .qh(chain_b[15]),
        .shift_load(sl_b), .clock_in_hibit(ci_b)
    );

    // Behavioural chains: whole chain as one register, head device in the MSBs.
    always @(posedge clk) begin
        if (!sl_a) chain_a <= q_a;
        else if (!ci_a) chain_a <= {chain_a[6:0], 1'b0};
        if (!sl_b) chain_b <= q_b;
        else if (!ci_b) chain_b <= {chain_b[14:0], 1'b0};
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          cyc;
        logic        chg;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [7:0]  last_a = '0;
    logic [15:0] last_b = '0;
    int load_cyc_a[$];

    task automatic push_a(input logic [7:0] word, input int done_cyc);
        exp_t e;
        e.data = {8'h00, word};
        e.cyc  = done_cyc;
        e.chg  = (word != last_a);
        last_a = word;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input logic [15:0] word, input int done_cyc);
        exp_t e;
        e.data = word;
        e.cyc  = done_cyc;
        e.chg  = (word != last_b);
        last_b = word;
        sb_b.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after an edge with cyc=k: start is sampled at k+1, done at k+W+2.
    task automatic start_a(input bit accepted);
        ifa.start = 1'b1;
        if (accepted) push_a(q_a, cyc + 10);
        tick(1);
        ifa.start = 1'b0;
    endtask

    task automatic start_b();
        ifb.start = 1'b1;
        push_b(q_b, cyc + 18);
        tick(1);
        ifb.start = 1'b0;
    endtask

    // Done monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (ifa.done) begin
            $display("A scan cyc=%0d data_out=%02h", cyc, ifa.data_out);
            if (sb_a.size() == 0) begin
                check("a_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                check("a_data", 32'(ifa.data_out), 32'(e.data));
                check("a_done_cyc", cyc, e.cyc);
`ifdef HC165_SCAN_CHANGE_EN
                check("a_changed", 32'(ifa.changed), 32'(e.chg));
`endif
            end
        end
        if (ifb.done) begin
            $display("B scan cyc=%0d data_out=%04h", cyc, ifb.data_out);
            if (sb_b.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                check("b_data", 32'(ifb.data_out), 32'(e.data));
                check("b_done_cyc", cyc, e.cyc);
`ifdef HC165_SCAN_CHANGE_EN
                check("b_changed", 32'(ifb.changed), 32'(e.chg));
`endif
            end
        end
    end

    // Load-pulse monitor for A: width of each shift_load low run and its cycle.
    logic sl_prev = 1'b1;
    int   load_run = 0;
    always @(negedge clk) begin
        if (!sl_a) begin
            if (!sl_prev) begin
                load_run++;
            end else begin
                load_run = 1;
                load_cyc_a.push_back(cyc);
            end
        end else if (!sl_prev) begin
            check("a_load_len", load_run, 1);
        end
        sl_prev = sl_a;
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.start = 1'b0; ifa.auto_en = 1'b0;
        ifb.start = 1'b0; ifb.auto_en = 1'b0;
        q_a = '0; q_b = '0;

        tick(3);
        @(negedge clk);
        check("rst_shift_load", 32'(sl_a), 1);
        check("rst_clk_inh", 32'(ci_a), 1);
        check("rst_busy", 32'(ifa.busy), 0);
        check("rst_done", 32'(ifa.done), 0);
        check("rst_data", 32'(ifa.data_out), 0);
        check("rst_b_busy", 32'(ifb.busy), 0);
        check("rst_b_data", 32'(ifb.data_out), 0);
`ifdef HC165_SCAN_CHANGE_EN
        check("rst_changed", 32'(ifa.changed), 0);
`endif
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2);

        // Single scans on both chains
        q_a = 8'hA5;
        start_a(1);
        tick(12);
        q_b = 16'h3C81;
        start_b();
        tick(20);

        // Starts during a scan are dropped; a start in the done cycle is taken
        q_a = 8'h96;
        start_a(1);
        tick(2);
        start_a(0);
        tick(4);
        start_a(0);
        tick(1);
        q_a = 8'h3E;
        start_a(1);
        tick(12);

        // Autonomous scans 13 cycles apart; auto_en dropped mid third scan
        load_cyc_a.delete();
        q_a = 8'hC3;
        begin
            int k;
            k = cyc;
            ifa.auto_en = 1'b1;
            push_a(q_a, k + 13);
            push_a(q_a, k + 26);
            push_a(q_a, k + 39);
        end
        tick(33);
        ifa.auto_en = 1'b0;
        tick(45);
        check("auto_load_count", load_cyc_a.size(), 3);
        for (int i = 1; i < load_cyc_a.size(); i++) begin
            check("auto_period", load_cyc_a[i] - load_cyc_a[i-1], 13);
        end

        // Reset during SHIFT cycle 4 aborts with no done
        q_a = 8'h7F;
        start_a(0);
        tick(5);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_shift_load", 32'(sl_a), 1);
        check("abort_clk_inh", 32'(ci_a), 1);
        check("abort_busy", 32'(ifa.busy), 0);
        check("abort_data", 32'(ifa.data_out), 0);
        check("abort_done", 32'(ifa.done), 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        last_a = '0;
        tick(15);

        // Sequence 00, 00, 5A after reset
        q_a = 8'h00;
        start_a(1);
        tick(11);
        start_a(1);
        tick(11);
        q_a = 8'h5A;
        start_a(1);
        tick(15);

        check("a_sb_empty", sb_a.size(), 0);
        check("b_sb_empty", sb_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hc165_scan_ctrl.md
# hc165_scan_ctrl

Sequencer for a daisy-chain of HD74HC165 parallel-in/serial-out shift registers. It drives each device's `shift_load` and `clock_in_hibit` pins, parallel-loads the chain, and clocks the bits out. It samples `qh` of the first device and presents the assembled word to the host logic with a start/busy/done handshake. Scans run on request or autonomously at a fixed interval. The block sits between the HC165 chain (same `clk`) and any consumer of the sampled inputs.

## Interface
- `NUM_DEV`, default 1: number of chained devices. Word width `W = 8*NUM_DEV`. Legal range 1..8.
- `GAP_CYCLES`, default 16: idle cycles between automatic scans. Legal range 0..65535.
- `clk`  in  1: single clock, shared with the HC165 chain.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle scan request.
- `auto_en`  in  1: enables autonomous periodic scanning.
- `qh`  in  1: serial output of the chain head device.
- `shift_load`  out  1: to every device. 0 = load, 1 = shift.
- `clock_in_hibit`  out  1: to every device. 1 = hold.
- `busy`  out  1: high while a scan is in progress.
- `done`  out  1: one-cycle pulse when `data_out` is updated.
- `data_out`  out  W: last completed scan.

## Operation
- FSM states: IDLE, LOAD, SHIFT.
- IDLE
  - Outputs: `shift_load=1`, `clock_in_hibit=1`, `busy=0`.
  - Leaves to LOAD on `start`, or on the gap counter reaching `GAP_CYCLES` while `auto_en=1`.
- LOAD (exactly 1 cycle)
  - Outputs: `shift_load=0`, `clock_in_hibit=0`, `busy=1`.
  - The devices load `q` at the closing edge. Next state is SHIFT.
- SHIFT (exactly W cycles)
  - Outputs: `shift_load=1`, `clock_in_hibit=0`, `busy=1`.
  - Each edge captures `qh` into the capture register LSB, shifting left, while the devices shift.
  - The bit counter counts 0..W-1. At count W-1 the state returns to IDLE.
  - The completed word goes to `data_out` and `done` pulses for one cycle.
- Bit order:
  - The first captured bit lands in `data_out[W-1]`, which is `q[7]` of the head device.
  - `data_out[7:0]` is the tail device's `q`.
- The extra shift on the final SHIFT edge is harmless: the next scan reloads the chain.
- `start` while `busy=1` is ignored and not queued.
- `start` in the same cycle as `done` is accepted (FSM is in IDLE), so back-to-back scans are possible.
- Gap counter
  - Clears on `done` and whenever `auto_en=0`. Counts only in IDLE.
  - `GAP_CYCLES=0` with `auto_en=1` gives continuous scanning.
  - `start` and an auto trigger in the same cycle launch a single scan.
- Dropping `auto_en` mid-scan does not abort the scan. It only suppresses further auto scans.
- `rst` mid-scan:
  - Aborts immediately and returns to IDLE with the hold outputs.
  - `data_out` clears and no `done` is generated.

## Timing
- Reset values: `shift_load=1`, `clock_in_hibit=1`, `busy=0`, `done=0`, `data_out=0`, FSM=IDLE, counters=0.
- All outputs are registered or decoded directly from FSM state. There is no combinational path from `start` or `qh` to any output.
- Scan latency, for `start` sampled at edge T:
  - LOAD occupies cycle T..T+1.
  - SHIFT occupies T+1..T+W+1.
  - `data_out` updates and `done=1` at edge T+W+1.
  - Total: W+1 cycles (9 for `NUM_DEV=1`).
- `busy` is high from edge T to edge T+W+1, i.e. W+1 cycles. It drops in the same cycle `done` rises.
- Auto-scan period, load edge to load edge: W+1+`GAP_CYCLES` cycles.
- `data_out` is stable between `done` pulses.

## Configuration
- `HC165_SCAN_CHANGE_EN` defined:
  - Adds output `changed` (1 bit, reset 0).
  - `changed` pulses together with `done` when the new word differs from the previous `data_out`.
  - The first scan after reset compares against 0.
- `HC165_SCAN_CHANGE_EN` undefined: no `changed` port and no comparison logic.

## Structure
- Package `hc165_scan_pkg`:
  - FSM state enum.
  - Localparams for the idle, load and shift pin encodings (`shift_load`, `clock_in_hibit`).
  - Counter width function (`$clog2`).
- Sub-module `hc165_capture`: W-bit serial-in capture register with clear, shift-enable and parallel output. The FSM, bit counter and gap counter stay in the top.

## Test plan
- `NUM_DEV=1`, chain loaded with `q=8'hA5`, `start` pulse → `shift_load=0` for exactly 1 cycle, `done` 9 cycles after `start`, `data_out=8'hA5`.
- `NUM_DEV=2`, head `q=8'h3C`, tail `q=8'h81` → `data_out=16'h3C81`, `done` 17 cycles after `start`.
- Extra `start` pulses at cycles 3 and 8 of a scan → ignored, a single `done`. `start` in the `done` cycle → second scan with `done` 9 cycles later.
- `auto_en=1`, `GAP_CYCLES=4`, `NUM_DEV=1` → LOAD cycles exactly 13 cycles apart. Clearing `auto_en` mid-scan → that scan completes and no further LOAD occurs.
- `rst` asserted in SHIFT cycle 4 → next cycle `shift_load=1`, `clock_in_hibit=1`, `busy=0`, `data_out=0`, no `done`.
- `HC165_SCAN_CHANGE_EN` defined, scans of `8'h00`, `8'h00`, `8'h5A` → `changed` = 0, 0, 1 alongside each `done`.
